// File: rtl/frame_seq_pkg.sv
// -----------------------------------------------------------------------------
// frame_seq_pkg
// Shared types and constants for the per-frame framebuffer write scheduler:
// FSM state encoding, framebuffer coordinate widths and default screen size.
// -----------------------------------------------------------------------------
package frame_seq_pkg;

  // Framebuffer coordinate widths (x covers 160 columns, y covers 120 rows)
  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;

  // Default screen dimensions
  localparam int unsigned DEFAULT_SCREEN_W = 160;
  localparam int unsigned DEFAULT_SCREEN_H = 120;

  // Frame scheduler states
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DRAW_START,
    DRAW,
    HOLD
  } state_t;

  // Cycle-count parameters of zero mean "one cycle"
  function automatic int unsigned at_least_one(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Raster-order x/y sweep counter over a SCREEN_W x SCREEN_H region.
// Ports:
//   clock   in   system clock
//   reset   in   synchronous, active-high; clears x/y to (0,0)
//   load    in   restart the sweep at (0,0)
//   inc     in   advance one pixel; x wraps at SCREEN_W-1 and bumps y
//   x       out  current column (registered)
//   y       out  current row (registered)
//   last_c  out  combinational: current pixel is (SCREEN_W-1, SCREEN_H-1)
// -----------------------------------------------------------------------------
module raster_counter
  import frame_seq_pkg::*;
#(
  parameter int unsigned SCREEN_W = DEFAULT_SCREEN_W,
  parameter int unsigned SCREEN_H = DEFAULT_SCREEN_H
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic           inc,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last_c
);

  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

  // Load wins over increment; y also wraps so the counter never leaves range
  always_ff @(posedge clock) begin
    if (reset || load) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

  assign last_c = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
// Per-frame scheduler and sole owner of the VGA framebuffer write port.
// Each frame: sweep the screen to BG_COLOR, pulse draw_start and forward the
// point drawer's writes until draw_done, then idle FRAME_WAIT_CYCLES cycles.
// Dropping enable lets the current frame finish through HOLD, then IDLE.
// Optional macro FRAME_SEQ_DRAW_TIMEOUT_EN adds a DRAW watchdog and the sticky
// draw_timeout output.
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   enable            level; run frames while high
//   draw_start        one-cycle pulse launching the point drawer
//   draw_x/y/color    drawer pixel, draw_writeEn drawer pixel valid
//   draw_done         drawer finished pulse
//   x/y/color/writeEn framebuffer write port (registered)
//   frame_done        one-cycle pulse on leaving DRAW
//   busy              high in every state except IDLE
//   draw_timeout      (macro only) sticky watchdog flag, cleared by reset
// -----------------------------------------------------------------------------
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int unsigned SCREEN_W            = DEFAULT_SCREEN_W,
  parameter int unsigned SCREEN_H            = DEFAULT_SCREEN_H,
  parameter int unsigned COLOR_CHANNEL_DEPTH = 1,
  parameter int unsigned BG_COLOR            = 0,
  parameter int unsigned FRAME_WAIT_CYCLES   = 1000,
  parameter int unsigned DRAW_TIMEOUT_CYCLES = 4096
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  output logic                             draw_start,
  input  logic [X_W-1:0]                   draw_x,
  input  logic [Y_W-1:0]                   draw_y,
  input  logic [3*COLOR_CHANNEL_DEPTH-1:0] draw_color,
  input  logic                             draw_writeEn,
  input  logic                             draw_done,
  output logic [X_W-1:0]                   x,
  output logic [Y_W-1:0]                   y,
  output logic [3*COLOR_CHANNEL_DEPTH-1:0] color,
  output logic                             writeEn,
  output logic                             frame_done,
  output logic                             busy
`ifdef FRAME_SEQ_DRAW_TIMEOUT_EN
  ,
  output logic                             draw_timeout
`endif
);

  localparam int unsigned    CW        = 3 * COLOR_CHANNEL_DEPTH;
  localparam logic [CW-1:0]  BG        = CW'(BG_COLOR);
  localparam int unsigned    HOLD_N    = at_least_one(FRAME_WAIT_CYCLES);
  localparam int unsigned    HOLD_W    = $clog2(HOLD_N) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_N - 1);

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_end_c;
  logic              sweep_load_c;
  logic              sweep_inc_c;
  logic [X_W-1:0]    sweep_x;
  logic [Y_W-1:0]    sweep_y;
  logic              sweep_last_c;

`ifdef FRAME_SEQ_DRAW_TIMEOUT_EN
  localparam int unsigned     WD_N    = at_least_one(DRAW_TIMEOUT_CYCLES);
  localparam int unsigned     WD_W    = $clog2(WD_N) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_N - 1);

  logic [WD_W-1:0] wd_cnt;
`endif

  assign hold_end_c   = (state == HOLD) && (hold_cnt == HOLD_LAST);

  // Sweep restarts at (0,0) on every transition into CLEAR
  assign sweep_load_c = enable && ((state == IDLE) || hold_end_c);
  assign sweep_inc_c  = (state == CLEAR);

  raster_counter #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_sweep (
    .clock  (clock),
    .reset  (reset),
    .load   (sweep_load_c),
    .inc    (sweep_inc_c),
    .x      (sweep_x),
    .y      (sweep_y),
    .last_c (sweep_last_c)
  );

  // Frame FSM with registered write-port and status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      color        <= '0;
      writeEn      <= 1'b0;
      draw_start   <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      hold_cnt     <= '0;
`ifdef FRAME_SEQ_DRAW_TIMEOUT_EN
      wd_cnt       <= '0;
      draw_timeout <= 1'b0;
`endif
    end else begin
      // Pulses and the write strobe default low every cycle
      writeEn    <= 1'b0;
      draw_start <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (enable) begin
            state <= CLEAR;
            busy  <= 1'b1;
          end
        end

        CLEAR: begin
          // Drawer inputs are ignored here, draw_done included
          writeEn <= 1'b1;
          x       <= sweep_x;
          y       <= sweep_y;
          color   <= BG;
          if (sweep_last_c) begin
            state <= DRAW_START;
          end
        end

        DRAW_START: begin
          draw_start <= 1'b1;
          state      <= DRAW;
`ifdef FRAME_SEQ_DRAW_TIMEOUT_EN
          wd_cnt     <= '0;
`endif
        end

        DRAW: begin
          // Pixel sampled with draw_done is still forwarded
          x       <= draw_x;
          y       <= draw_y;
          color   <= draw_color;
          writeEn <= draw_writeEn;
          if (draw_done) begin
            state      <= HOLD;
            frame_done <= 1'b1;
            hold_cnt   <= '0;
          end
`ifdef FRAME_SEQ_DRAW_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            writeEn      <= 1'b0;
            state        <= HOLD;
            frame_done   <= 1'b1;
            draw_timeout <= 1'b1;
            hold_cnt     <= '0;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end

        HOLD: begin
          if (hold_end_c) begin
            if (enable) begin
              state <= CLEAR;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
// Directed self-checking bench: a small 4x3 instance for sweep, passthrough,
// frame interval, enable drop and watchdog; a default-size instance for the
// mid-sweep reset at pixel (37,5).
// -----------------------------------------------------------------------------
module tb_frame_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Small instance (4x3, BG 3'b010, 5-cycle hold, 8-cycle watchdog)
  logic       reset, enable, draw_start, draw_writeEn, draw_done;
  logic [7:0] draw_x, x;
  logic [6:0] draw_y, y;
  logic [2:0] draw_color, color;
  logic       writeEn, frame_done, busy;
`ifdef FRAME_SEQ_DRAW_TIMEOUT_EN
  logic       draw_timeout;
`endif

  // Default-size instance
  logic       reset_b, enable_b, draw_start_b, writeEn_b, frame_done_b, busy_b;
  logic [7:0] x_b;
  logic [6:0] y_b;
  logic [2:0] color_b;
`ifdef FRAME_SEQ_DRAW_TIMEOUT_EN
  logic       draw_timeout_b;
`endif

  frame_sequencer #(
    .SCREEN_W (4), .SCREEN_H (3), .COLOR_CHANNEL_DEPTH (1),
    .BG_COLOR (2), .FRAME_WAIT_CYCLES (5), .DRAW_TIMEOUT_CYCLES (8)
  ) dut (
    .clock (clock), .reset (reset), .enable (enable),
    .draw_start (draw_start), .draw_x (draw_x), .draw_y (draw_y),
    .draw_color (draw_color), .draw_writeEn (draw_writeEn),
    .draw_done (draw_done), .x (x), .y (y), .color (color),
    .writeEn (writeEn), .frame_done (frame_done), .busy (busy)
`ifdef FRAME_SEQ_DRAW_TIMEOUT_EN
    , .draw_timeout (draw_timeout)
`endif
  );

  frame_sequencer dut_big (
    .clock (clock), .reset (reset_b), .enable (enable_b),
    .draw_start (draw_start_b), .draw_x (8'd0), .draw_y (7'd0),
    .draw_color (3'd0), .draw_writeEn (1'b0), .draw_done (1'b0),
    .x (x_b), .y (y_b), .color (color_b),
    .writeEn (writeEn_b), .frame_done (frame_done_b), .busy (busy_b)
`ifdef FRAME_SEQ_DRAW_TIMEOUT_EN
    , .draw_timeout (draw_timeout_b)
`endif
  );

  typedef struct {
    logic [7:0] dx;
    logic [6:0] dy;
    logic [2:0] dc;
    logic       dwe;
    logic       ddone;
    logic       exp_we;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    logic       exp_fd;
  } vec_t;

  vec_t tbl [6];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   fd_cyc, ds_cyc, wcount, bad;
  logic found, flag;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance to the next falling edge, where outputs are sampled and inputs driven
  task automatic step();
    @(negedge clock);
    cyc++;
  endtask

  initial begin
    // inputs applied in DRAW; expected outputs one cycle later
    tbl[0] = '{8'd10, 7'd20, 3'b111, 1'b1, 1'b0, 1'b1, 8'd10, 7'd20, 3'b111, 1'b0};
    tbl[1] = '{8'd11, 7'd21, 3'b111, 1'b1, 1'b0, 1'b1, 8'd11, 7'd21, 3'b111, 1'b0};
    tbl[2] = '{8'd0,  7'd0,  3'b000, 1'b0, 1'b0, 1'b0, 8'd0,  7'd0,  3'b000, 1'b0};
    tbl[3] = '{8'd50, 7'd60, 3'b101, 1'b1, 1'b1, 1'b1, 8'd50, 7'd60, 3'b101, 1'b1};
    tbl[4] = '{8'd70, 7'd80, 3'b011, 1'b1, 1'b0, 1'b0, 8'd0,  7'd0,  3'b000, 1'b0};
    tbl[5] = '{8'd71, 7'd81, 3'b011, 1'b1, 1'b1, 1'b0, 8'd0,  7'd0,  3'b000, 1'b0};

    reset = 1'b1; enable = 1'b0; reset_b = 1'b1; enable_b = 1'b0;
    draw_x = '0; draw_y = '0; draw_color = '0; draw_writeEn = 1'b0; draw_done = 1'b0;
    repeat (3) step();

    check("rst_writeEn", writeEn, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_color", color, 0);
    check("rst_busy", busy, 0);
    check("rst_draw_start", draw_start, 0);
    check("rst_frame_done", frame_done, 0);
`ifdef FRAME_SEQ_DRAW_TIMEOUT_EN
    check("rst_draw_timeout", draw_timeout, 0);
`endif

    // Reset in the middle of a full-size sweep
    reset_b = 1'b0; enable_b = 1'b1; found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (writeEn_b && x_b == 8'd37 && y_b == 7'd5) found = 1'b1;
    end
    check("big_reach_37_5", found, 1);
    reset_b = 1'b1;
    step();
    check("big_rst_writeEn", writeEn_b, 0);
    check("big_rst_x", x_b, 0);
    check("big_rst_y", y_b, 0);
    check("big_rst_busy", busy_b, 0);
    check("big_rst_draw_start", draw_start_b, 0);
    enable_b = 1'b0;
    step();
    reset_b = 1'b0;
    step();
    check("big_idle_busy", busy_b, 0);
    check("big_idle_writeEn", writeEn_b, 0);

    // Frame 1: clear sweep in raster order
    reset = 1'b0;
    step();
    enable = 1'b1;
    step();
    check("clr_busy", busy, 1);
    check("clr_pre_writeEn", writeEn, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("clr_we_%0d", i), writeEn, 1);
      check($sformatf("clr_x_%0d", i), x, i % 4);
      check($sformatf("clr_y_%0d", i), y, i / 4);
      check($sformatf("clr_color_%0d", i), color, 3'b010);
    end
    step();
    check("clr_end_writeEn", writeEn, 0);
    check("draw_start_pulse", draw_start, 1);

    // Draw passthrough table
    fd_cyc = -1;
    for (int k = 0; k < 6; k++) begin
      draw_x = tbl[k].dx; draw_y = tbl[k].dy; draw_color = tbl[k].dc;
      draw_writeEn = tbl[k].dwe; draw_done = tbl[k].ddone;
      step();
      check($sformatf("tbl%0d_writeEn", k), writeEn, tbl[k].exp_we);
      if (tbl[k].exp_we) begin
        check($sformatf("tbl%0d_x", k), x, tbl[k].ex);
        check($sformatf("tbl%0d_y", k), y, tbl[k].ey);
        check($sformatf("tbl%0d_color", k), color, tbl[k].ec);
      end
      check($sformatf("tbl%0d_frame_done", k), frame_done, tbl[k].exp_fd);
      check($sformatf("tbl%0d_draw_start", k), draw_start, 0);
      check($sformatf("tbl%0d_busy", k), busy, 1);
      if (frame_done) fd_cyc = cyc;
    end
    draw_x = '0; draw_y = '0; draw_color = '0; draw_writeEn = 1'b0; draw_done = 1'b0;

    // Frame interval: next sweep's first write six samples after frame_done
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (writeEn) found = 1'b1;
    end
    check("next_clear_seen", found, 1);
    check("hold_interval", cyc - fd_cyc, 6);
    check("next_clear_x", x, 0);
    check("next_clear_y", y, 0);

    // Frame 2: drawer inputs (draw_done too) must be ignored during CLEAR
    draw_done = 1'b1; draw_writeEn = 1'b1;
    draw_x = 8'd99; draw_y = 7'd99; draw_color = 3'b101;
    wcount = 1; bad = 0; found = 1'b0; flag = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (draw_start) found = 1'b1;
      else if (writeEn) begin
        wcount++;
        if (color != 3'b010 || x >= 8'd4 || y >= 7'd3) bad++;
      end
      if (frame_done) flag = 1'b1;
    end
    check("f2_draw_start_seen", found, 1);
    check("f2_clear_writes", wcount, 12);
    check("f2_clear_bad_pixels", bad, 0);
    check("f2_no_early_frame_done", flag, 0);

    // Drop enable during DRAW: frame completes, then IDLE
    draw_done = 1'b0; draw_writeEn = 1'b0; enable = 1'b0;
    step();
    step();
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    check("f2_frame_done", frame_done, 1);
    for (int i = 1; i < 5; i++) begin
      step();
      check($sformatf("f2_hold_busy_%0d", i), busy, 1);
    end
    step();
    check("f2_idle_busy", busy, 0);
    check("f2_idle_writeEn", writeEn, 0);
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (writeEn || busy || draw_start) flag = 1'b1;
    end
    check("f2_stays_idle", flag, 0);

`ifdef FRAME_SEQ_DRAW_TIMEOUT_EN
    // Watchdog: draw_done never arrives
    check("wd_pre_timeout", draw_timeout, 0);
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (draw_start) found = 1'b1;
    end
    check("wd_draw_start_seen", found, 1);
    ds_cyc = cyc;
    draw_writeEn = 1'b1; draw_x = 8'd3; draw_y = 7'd2; draw_color = 3'b001;
    enable = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (frame_done) found = 1'b1;
    end
    check("wd_frame_done_seen", found, 1);
    check("wd_draw_cycles", cyc - ds_cyc, 8);
    check("wd_draw_timeout", draw_timeout, 1);
    check("wd_writeEn_forced", writeEn, 0);
    draw_writeEn = 1'b0;
    repeat (30) step();
    check("wd_sticky", draw_timeout, 1);
    check("wd_idle_busy", busy, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("wd_cleared_by_reset", draw_timeout, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Per-frame scheduler for the VGA framebuffer write port.
- Each frame it sweeps the whole screen to a background colour, then launches the point-drawing engine and forwards its pixel writes, then waits a fixed frame interval before the next frame.
- Sole owner of the adapter's x/y/colour/writeEn inputs, so the clear sweep and the point drawer never contend for the write port.

Parameters:
- SCREEN_W, 160, columns swept; x counter width 8.
- SCREEN_H, 120, rows swept; y counter width 7.
- COLOR_CHANNEL_DEPTH, 1, bits per colour channel; colour width 3*COLOR_CHANNEL_DEPTH.
- BG_COLOR, 0, colour written during clear.
- FRAME_WAIT_CYCLES, 1000, HOLD length in cycles (0 treated as 1).
- DRAW_TIMEOUT_CYCLES, 4096, DRAW watchdog limit (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  level; run frames while high
- draw_start  out  1  one-cycle pulse launching the point drawer
- draw_x  in  8  drawer pixel x
- draw_y  in  7  drawer pixel y
- draw_color  in  3*CCD  drawer pixel colour
- draw_writeEn  in  1  drawer pixel valid
- draw_done  in  1  drawer finished pulse
- x  out  8  framebuffer x
- y  out  7  framebuffer y
- color  out  3*CCD  framebuffer colour
- writeEn  out  1  framebuffer write strobe
- frame_done  out  1  one-cycle pulse at end of DRAW
- busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered.
- Reset (any state, any cycle): state=IDLE; x=0, y=0, color=0; writeEn=0, draw_start=0, frame_done=0, busy=0; counters cleared.

State machine:
- IDLE -> CLEAR when enable=1. The counters load (0,0) in this transition.
- CLEAR: each cycle writeEn=1, x/y=counters, color=BG_COLOR.
  - x increments each cycle; on x=SCREEN_W-1, x wraps to 0 and y increments.
  - After the write of (SCREEN_W-1, SCREEN_H-1) -> DRAW_START.
  - Exactly SCREEN_W*SCREEN_H writes, in raster order.
  - draw_* inputs are ignored, including draw_done.
- DRAW_START: writeEn=0, draw_start=1 for exactly this cycle -> DRAW.
- DRAW: x/y/color/writeEn take draw_x/draw_y/draw_color/draw_writeEn with 1-cycle latency.
  - On draw_done=1 -> HOLD, with frame_done=1 on the next cycle.
  - A draw_writeEn arriving in the same cycle as draw_done is still forwarded.
  - Inputs after that cycle are dropped (writeEn=0 in HOLD).
- HOLD: writeEn=0; counts FRAME_WAIT_CYCLES (minimum 1) cycles.
  - Then -> CLEAR if enable=1, else -> IDLE.
- enable deasserted mid-frame: the current frame completes through HOLD, then the block goes to IDLE. There is no abort.
- Every write uses counters held in range; x<SCREEN_W and y<SCREEN_H always hold during CLEAR.

Optional Feature:
- Macro FRAME_SEQ_DRAW_TIMEOUT_EN.
- Defined: a DRAW watchdog counts cycles in DRAW. On reaching DRAW_TIMEOUT_CYCLES without draw_done:
  - force writeEn=0;
  - go to HOLD;
  - raise frame_done together with a sticky output draw_timeout (1 bit), which is cleared only by reset.
- Undefined: no watchdog, no draw_timeout port; DRAW waits for draw_done indefinitely.

Decomposition:
- Package frame_seq_pkg holds:
  - the state enum (IDLE, CLEAR, DRAW_START, DRAW, HOLD);
  - the x/y width constants (8, 7);
  - the default screen dimensions.
- One natural sub-module, raster_counter: the x/y sweep counter with a load, an increment, and a last-pixel flag. It is reused by any future region-clear block.

Test Plan:
- Reset: assert reset mid-CLEAR at pixel (37,5) -> next cycle writeEn=0, x=0, y=0, busy=0, state IDLE; no draw_start.
- Clear sweep (SCREEN_W=4, SCREEN_H=3, BG_COLOR=3'b010):
  - enable=1 -> exactly 12 consecutive writeEn cycles, (0,0),(1,0)..(3,2), all color=010;
  - then a single draw_start pulse.
- Draw passthrough: drawer drives (10,20,3'b111) then (11,21,3'b111) with writeEn, then draw_done -> identical writes appear one cycle later, then frame_done pulses once.
- Done coincident with write: draw_writeEn=1 at (50,60) in the same cycle as draw_done=1 -> write (50,60) forwarded; a later draw_writeEn is not forwarded.
- Frame interval/enable drop (FRAME_WAIT_CYCLES=5):
  - enable held high -> next CLEAR starts 5 cycles after HOLD entry;
  - enable dropped during DRAW -> frame finishes, then IDLE with busy=0.
- Timeout (macro defined, DRAW_TIMEOUT_CYCLES=8): draw_done never asserted -> after 8 DRAW cycles, frame_done=1 and draw_timeout=1, which stays 1 until reset.
